// File: rtl/fp_div_nr_seq.sv
// fp_div_nr_seq: sequential binary32 divider, linear reciprocal seed refined by Newton-Raphson.
// Define FPDIV_EXCEPTION_FLAGS_EN to add the fflags {NV,DZ,OF,UF,NX} output.
module fp_div_nr_seq #(
  parameter int          ITERATIONS = 3,
  parameter logic [31:0] SEED_C0    = 32'h4034_B4B5,
  parameter logic [31:0] SEED_C1    = 32'h3FF0_F0F1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] quotient
`ifdef FPDIV_EXCEPTION_FLAGS_EN
  ,
  output logic [4:0]  fflags
`endif
);
  typedef enum logic [3:0] {IDLE, SEED_MUL, SEED_SUB, IT_MUL1, IT_SUB, IT_MUL2, FIN_MUL, ADJ, DONE} state_t;
  // Operands are positive with a 32-bit significand (hidden one at bit 31) so the final truncation dominates error.
  localparam logic signed [9:0] C0_E  = 10'(SEED_C0[30:23]);
  localparam logic signed [9:0] C1_E  = 10'(SEED_C1[30:23]);
  localparam logic [31:0]       C0_M  = {1'b1, SEED_C0[22:0], 8'h0};
  localparam logic [31:0]       C1_M  = {1'b1, SEED_C1[22:0], 8'h0};
  localparam logic signed [9:0] TWO_E = 10'sd128;
  localparam logic signed [9:0] D_E   = 10'sd126;
  state_t state_q, state_d;
  logic signed [9:0] a_e_q, a_e_d, x_e_q, x_e_d, t_e_q, t_e_d, ediff_q, ediff_d;
  logic [31:0] a_m_q, a_m_d, d_m_q, d_m_d, x_m_q, x_m_d, t_m_q, t_m_d, quotient_q, quotient_d;
  logic sign_q, sign_d, out_valid_q, out_valid_d, accept;
  logic [2:0] it_q, it_d;
  logic a_zero, b_zero, a_inf, b_inf, nv, dz, special;
  logic [31:0] spec_res;
  logic signed [9:0] ma_e, mb_e, mul_e, sa_e, sh, sub_e, ne;
  logic [31:0] ma_m, mb_m, mul_m, sa_m, bm, diff, sub_m, adj_res;
  logic [32:0] prod_hi;
  logic [4:0] lz;
  logic of, uf;
  always_comb begin
    a_zero   = dividend[30:23] == 8'h00;
    b_zero   = divisor[30:23] == 8'h00;
    a_inf    = dividend[30:23] == 8'hFF && dividend[22:0] == 23'h0;
    b_inf    = divisor[30:23] == 8'hFF && divisor[22:0] == 23'h0;
    nv       = (dividend[30:23] == 8'hFF && !a_inf) || (divisor[30:23] == 8'hFF && !b_inf)
               || (a_zero && b_zero) || (a_inf && b_inf);
    dz       = b_zero && !nv && !a_inf;
    special  = nv || a_zero || b_zero || a_inf || b_inf;
    spec_res = nv ? 32'h7FC0_0000 : (b_zero || a_inf) ? {dividend[31] ^ divisor[31], 8'hFF, 23'h0}
                                                      : {dividend[31] ^ divisor[31], 31'h0};
  end
  always_comb begin
    ma_e    = state_q == SEED_MUL ? C1_E : x_e_q;
    ma_m    = state_q == SEED_MUL ? C1_M : x_m_q;
    mb_e    = state_q == IT_MUL2 ? t_e_q : state_q == FIN_MUL ? a_e_q : D_E;
    mb_m    = state_q == IT_MUL2 ? t_m_q : state_q == FIN_MUL ? a_m_q : d_m_q;
    prod_hi = 33'((64'(ma_m) * 64'(mb_m)) >> 31);
    mul_m   = prod_hi[32] ? prod_hi[32:1] : prod_hi[31:0];
    mul_e   = ma_e + mb_e - 10'sd127 + (prod_hi[32] ? 10'sd1 : 10'sd0);
  end
  // Subtraction only ever sees a > b > 0 (seed constant or 2.0 minus a product near one).
  always_comb begin
    sa_e = state_q == SEED_SUB ? C0_E : TWO_E;
    sa_m = state_q == SEED_SUB ? C0_M : 32'h8000_0000;
    sh   = sa_e - t_e_q;
    bm   = sh > 10'sd31 ? 32'h0 : t_m_q >> sh[4:0];
    diff = sa_m - bm;
    lz   = 5'd0;
    for (int i = 0; i < 32; i++) if (diff[i]) lz = 5'(31 - i);
    sub_m = diff << lz;
    sub_e = sa_e - 10'(lz);
  end
  always_comb begin
    ne      = t_e_q + ediff_q;
    of      = ne >= 10'sd255;
    uf      = ne <= 10'sd0;
    adj_res = of ? {sign_q, 8'hFF, 23'h0} : uf ? {sign_q, 31'h0} : {sign_q, ne[7:0], t_m_q[30:8]};
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= IDLE;
    else state_q <= state_d;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (in_valid) state_d = special ? DONE : SEED_MUL;
      SEED_MUL: state_d = SEED_SUB;
      SEED_SUB: state_d = IT_MUL1;
      IT_MUL1:  state_d = IT_SUB;
      IT_SUB:   state_d = IT_MUL2;
      IT_MUL2:  state_d = it_q + 3'd1 == 3'(ITERATIONS) ? FIN_MUL : IT_MUL1;
      FIN_MUL:  state_d = ADJ;
      ADJ:      state_d = DONE;
      DONE:     if (out_valid_q && out_ready) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end
  always_comb begin
    in_ready  = state_q == IDLE;
    out_valid = out_valid_q;
    quotient  = quotient_q;
  end
  always_comb begin
    accept      = state_q == IDLE && in_valid;
    a_e_d       = accept ? 10'(dividend[30:23]) : a_e_q;
    a_m_d       = accept ? {1'b1, dividend[22:0], 8'h0} : a_m_q;
    d_m_d       = accept ? {1'b1, divisor[22:0], 8'h0} : d_m_q;
    ediff_d     = accept ? 10'sd126 - 10'(divisor[30:23]) : ediff_q;
    sign_d      = accept ? dividend[31] ^ divisor[31] : sign_q;
    it_d        = accept ? 3'd0 : state_q == IT_MUL2 ? it_q + 3'd1 : it_q;
    x_e_d       = state_q == SEED_SUB ? sub_e : state_q == IT_MUL2 ? mul_e : x_e_q;
    x_m_d       = state_q == SEED_SUB ? sub_m : state_q == IT_MUL2 ? mul_m : x_m_q;
    t_e_d       = state_q inside {SEED_MUL, IT_MUL1, FIN_MUL} ? mul_e : state_q == IT_SUB ? sub_e : t_e_q;
    t_m_d       = state_q inside {SEED_MUL, IT_MUL1, FIN_MUL} ? mul_m : state_q == IT_SUB ? sub_m : t_m_q;
    quotient_d  = accept && special ? spec_res : state_q == ADJ ? adj_res : quotient_q;
    out_valid_d = state_q == DONE && !(out_valid_q && out_ready);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      a_e_q       <= '0;
      a_m_q       <= '0;
      d_m_q       <= '0;
      x_e_q       <= '0;
      x_m_q       <= '0;
      t_e_q       <= '0;
      t_m_q       <= '0;
      ediff_q     <= '0;
      sign_q      <= 1'b0;
      it_q        <= '0;
      quotient_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      a_e_q       <= a_e_d;
      a_m_q       <= a_m_d;
      d_m_q       <= d_m_d;
      x_e_q       <= x_e_d;
      x_m_q       <= x_m_d;
      t_e_q       <= t_e_d;
      t_m_q       <= t_m_d;
      ediff_q     <= ediff_d;
      sign_q      <= sign_d;
      it_q        <= it_d;
      quotient_q  <= quotient_d;
      out_valid_q <= out_valid_d;
    end
`ifdef FPDIV_EXCEPTION_FLAGS_EN
  logic [4:0] flags_q, flags_d;
  always_comb begin
    flags_d = accept ? (special ? {nv, dz, 3'b000} : 5'b0) : state_q == ADJ ? {2'b00, of, uf, of | uf} : flags_q;
    fflags  = out_valid_q ? flags_q : 5'b0;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) flags_q <= '0;
    else flags_q <= flags_d;
`endif
endmodule
